// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: three requesters in, one arbitrated write out.
`timescale 1ns/1ps
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [2:0]        Req;
    logic [ADDR_W-1:0] ReqAddr0;
    logic [ADDR_W-1:0] ReqAddr1;
    logic [ADDR_W-1:0] ReqAddr2;
    logic [DATA_W-1:0] ReqData0;
    logic [DATA_W-1:0] ReqData1;
    logic [DATA_W-1:0] ReqData2;
    logic [2:0]        Gnt;
    logic              RegWrite;
    logic [ADDR_W-1:0] WAddr;
    logic [DATA_W-1:0] WData;
    logic              Dropped;
    logic [7:0]        DropCount;

    modport master (
        output Req, ReqAddr0, ReqAddr1, ReqAddr2, ReqData0, ReqData1, ReqData2,
        input  Gnt, RegWrite, WAddr, WData, Dropped, DropCount
    );

    modport slave (
        input  Req, ReqAddr0, ReqAddr1, ReqAddr2, ReqData0, ReqData1, ReqData2,
        output Gnt, RegWrite, WAddr, WData, Dropped, DropCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging three writeback sources onto one register-file write port.
// Optional macro REGWR_PROTECT_KERNEL_EN also discards writes to registers 26 and 27.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    regfile_write_arbiter_if.slave  bus
);

    logic [1:0]        ptr_q,       ptr_d;
    logic              regwrite_q,  regwrite_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              dropped_q,   dropped_d;
    logic [7:0]        dropcount_q, dropcount_d;

    logic [2:0]        gnt_s;
    logic              xfer_s;
    logic              drop_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    // Scan from ptr upward (mod 3); an illegal ptr scans as if it were 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      g = 3'b010;
                else if (req[2]) g = 3'b100;
                else if (req[0]) g = 3'b001;
                else             g = 3'b000;
            end
            2'd2: begin
                if (req[2])      g = 3'b100;
                else if (req[0]) g = 3'b001;
                else if (req[1]) g = 3'b010;
                else             g = 3'b000;
            end
            default: begin
                if (req[0])      g = 3'b001;
                else if (req[1]) g = 3'b010;
                else if (req[2]) g = 3'b100;
                else             g = 3'b000;
            end
        endcase
        return g;
    endfunction

    function automatic logic is_discarded(input logic [ADDR_W-1:0] addr);
        logic d;
        d = (addr == {ADDR_W{1'b0}});
`ifdef REGWR_PROTECT_KERNEL_EN
        if ((addr == ADDR_W'(5'd26)) || (addr == ADDR_W'(5'd27))) begin
            d = 1'b1;
        end else begin
            d = d;
        end
`endif
        return d;
    endfunction

    // Grant, transfer selection and next-state computation.
    always_comb begin
        gnt_s       = 3'b000;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        ptr_d       = ptr_q;
        if (!Rst_n) begin
            gnt_s = 3'b000;
        end else begin
            gnt_s = rr_pick(bus.Req, ptr_q);
        end
        case (gnt_s)
            3'b001: begin
                sel_addr_s = bus.ReqAddr0;
                sel_data_s = bus.ReqData0;
                ptr_d      = 2'd1;
            end
            3'b010: begin
                sel_addr_s = bus.ReqAddr1;
                sel_data_s = bus.ReqData1;
                ptr_d      = 2'd2;
            end
            3'b100: begin
                sel_addr_s = bus.ReqAddr2;
                sel_data_s = bus.ReqData2;
                ptr_d      = 2'd0;
            end
            default: begin
                sel_addr_s = {ADDR_W{1'b0}};
                sel_data_s = {DATA_W{1'b0}};
                ptr_d      = ptr_q;
            end
        endcase
        xfer_s     = |gnt_s;
        drop_s     = xfer_s && is_discarded(sel_addr_s);
        regwrite_d = xfer_s && !drop_s;
        dropped_d  = drop_s;
        if (regwrite_d) begin
            waddr_d = sel_addr_s;
            wdata_d = sel_data_s;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
        if (drop_s && (dropcount_q != 8'hFF)) begin
            dropcount_d = dropcount_q + 8'd1;
        end else begin
            dropcount_d = dropcount_q;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q       <= 2'd0;
            regwrite_q  <= 1'b0;
            waddr_q     <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            dropped_q   <= 1'b0;
            dropcount_q <= 8'd0;
        end else begin
            ptr_q       <= ptr_d;
            regwrite_q  <= regwrite_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            dropped_q   <= dropped_d;
            dropcount_q <= dropcount_d;
        end
    end

    assign bus.Gnt       = gnt_s;
    assign bus.RegWrite  = regwrite_q;
    assign bus.WAddr     = waddr_q;
    assign bus.WData     = wdata_q;
    assign bus.Dropped   = dropped_q;
    assign bus.DropCount = dropcount_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.Req      = 3'b000;
        bus.ReqAddr0 = 5'd0;
        bus.ReqAddr1 = 5'd0;
        bus.ReqAddr2 = 5'd0;
        bus.ReqData0 = 32'd0;
        bus.ReqData1 = 32'd0;
        bus.ReqData2 = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.Req = 3'b000;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.Req = 3'b111;
        bus.ReqAddr0 = 5'd1;
        #12;
        n_tests++; if (bus.Gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", bus.Gnt); end
        n_tests++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", bus.RegWrite); end
        n_tests++; if (bus.WAddr !== 5'd0 || bus.WData !== 32'd0) begin n_fail++; $display("FAIL reset_wbus: got %0h/%0h expected 0/0", bus.WAddr, bus.WData); end
        n_tests++; if (bus.Dropped !== 1'b0 || bus.DropCount !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %b/%0d expected 0/0", bus.Dropped, bus.DropCount); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.Req = 3'b010; bus.ReqAddr1 = 5'd5; bus.ReqData1 = 32'h0000_1234;
        #1;
        n_tests++; if (bus.Gnt !== 3'b010) begin n_fail++; $display("FAIL single_gnt: got %b expected 010", bus.Gnt); end
        next_cycle();
        bus.Req = 3'b000;
        n_tests++; if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'd5 || bus.WData !== 32'h0000_1234)
            begin n_fail++; $display("FAIL single_write: got we=%b a=%0d d=%0h expected 1/5/1234", bus.RegWrite, bus.WAddr, bus.WData); end
        next_cycle();
        n_tests++; if (bus.RegWrite !== 1'b0 || bus.WAddr !== 5'd5 || bus.WData !== 32'h0000_1234)
            begin n_fail++; $display("FAIL single_idle_hold: got we=%b a=%0d d=%0h expected 0/5/1234", bus.RegWrite, bus.WAddr, bus.WData); end
    endtask

    task automatic test_all_request();
        logic [2:0] exp_g [0:5];
        int         exp_i [0:5];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
        exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 2; exp_i[3] = 0; exp_i[4] = 1; exp_i[5] = 2;
        apply_reset();
        @(negedge clk);
        bus.ReqAddr0 = 5'd7; bus.ReqAddr1 = 5'd8; bus.ReqAddr2 = 5'd9;
        bus.ReqData0 = 32'hA000_0000; bus.ReqData1 = 32'hA000_0001; bus.ReqData2 = 32'hA000_0002;
        bus.Req = 3'b111;
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k > 0) begin
                n_tests++;
                if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'(7 + exp_i[k-1]) || bus.WData !== (32'hA000_0000 + 32'(exp_i[k-1])))
                    begin n_fail++; $display("FAIL all_write[%0d]: got we=%b a=%0d d=%0h expected 1/%0d/%0h", k-1, bus.RegWrite, bus.WAddr, bus.WData, 7 + exp_i[k-1], 32'hA000_0000 + 32'(exp_i[k-1])); end
            end
            if (k < 6) begin
                n_tests++;
                if (bus.Gnt !== exp_g[k]) begin n_fail++; $display("FAIL all_gnt[%0d]: got %b expected %b", k, bus.Gnt, exp_g[k]); end
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.Req = 3'b000;
        next_cycle();
        n_tests++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL all_after_idle: got %b expected 0", bus.RegWrite); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        bus.Req = 3'b001; bus.ReqAddr0 = 5'd0; bus.ReqData0 = 32'h55;
        #1;
        n_tests++; if (bus.Gnt !== 3'b001) begin n_fail++; $display("FAIL zero_gnt: got %b expected 001", bus.Gnt); end
        next_cycle();
        bus.Req = 3'b000;
        n_tests++; if (bus.RegWrite !== 1'b0 || bus.Dropped !== 1'b1 || bus.DropCount !== 8'd1)
            begin n_fail++; $display("FAIL zero_drop: got we=%b drop=%b cnt=%0d expected 0/1/1", bus.RegWrite, bus.Dropped, bus.DropCount); end
        n_tests++; if (bus.WAddr !== 5'd9) begin n_fail++; $display("FAIL zero_waddr_hold: got %0d expected 9", bus.WAddr); end
        next_cycle();
        n_tests++; if (bus.Dropped !== 1'b0 || bus.DropCount !== 8'd1)
            begin n_fail++; $display("FAIL zero_pulse_end: got drop=%b cnt=%0d expected 0/1", bus.Dropped, bus.DropCount); end
    endtask

    task automatic test_kernel();
        @(negedge clk);
        bus.Req = 3'b100; bus.ReqAddr2 = 5'd26; bus.ReqData2 = 32'h0000_CAFE;
        #1;
        n_tests++; if (bus.Gnt !== 3'b100) begin n_fail++; $display("FAIL kernel_gnt: got %b expected 100", bus.Gnt); end
        next_cycle();
        bus.Req = 3'b000;
`ifdef REGWR_PROTECT_KERNEL_EN
        n_tests++; if (bus.RegWrite !== 1'b0 || bus.Dropped !== 1'b1 || bus.DropCount !== 8'd2)
            begin n_fail++; $display("FAIL kernel_drop: got we=%b drop=%b cnt=%0d expected 0/1/2", bus.RegWrite, bus.Dropped, bus.DropCount); end
`else
        n_tests++; if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'd26 || bus.WData !== 32'h0000_CAFE || bus.Dropped !== 1'b0)
            begin n_fail++; $display("FAIL kernel_write: got we=%b a=%0d d=%0h drop=%b expected 1/26/cafe/0", bus.RegWrite, bus.WAddr, bus.WData, bus.Dropped); end
`endif
    endtask

    task automatic test_late_drop();
        @(negedge clk);
        bus.Req = 3'b110;
        bus.ReqAddr1 = 5'd12; bus.ReqData1 = 32'h111;
        bus.ReqAddr2 = 5'd13; bus.ReqData2 = 32'h222;
        #1;
        n_tests++; if (bus.Gnt !== 3'b010) begin n_fail++; $display("FAIL late_gnt: got %b expected 010", bus.Gnt); end
        next_cycle();
        bus.Req = 3'b000;
        #1;
        n_tests++; if (bus.Gnt !== 3'b000) begin n_fail++; $display("FAIL late_gnt_zero: got %b expected 000", bus.Gnt); end
        n_tests++; if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'd12) begin n_fail++; $display("FAIL late_write1: got we=%b a=%0d expected 1/12", bus.RegWrite, bus.WAddr); end
        next_cycle();
        n_tests++; if (bus.RegWrite !== 1'b0 || bus.WAddr !== 5'd12 || bus.WData !== 32'h111)
            begin n_fail++; $display("FAIL late_no_write2: got we=%b a=%0d d=%0h expected 0/12/111", bus.RegWrite, bus.WAddr, bus.WData); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus.Req = 3'b001; bus.ReqAddr0 = 5'd0; bus.ReqData0 = 32'hDEAD;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.Req = 3'b000;
        #1;
        n_tests++; if (bus.DropCount !== 8'd255 || bus.Dropped !== 1'b1 || bus.RegWrite !== 1'b0)
            begin n_fail++; $display("FAIL sat_count: got cnt=%0d drop=%b we=%b expected 255/1/0", bus.DropCount, bus.Dropped, bus.RegWrite); end
        next_cycle();
        n_tests++; if (bus.DropCount !== 8'd255 || bus.Dropped !== 1'b0)
            begin n_fail++; $display("FAIL sat_hold: got cnt=%0d drop=%b expected 255/0", bus.DropCount, bus.Dropped); end
    endtask

    task automatic test_midrun_reset();
        apply_reset();
        @(negedge clk);
        bus.ReqAddr0 = 5'd3; bus.ReqAddr1 = 5'd4; bus.ReqAddr2 = 5'd5;
        bus.ReqData0 = 32'h30; bus.ReqData1 = 32'h40; bus.ReqData2 = 32'h50;
        bus.Req = 3'b111;
        #1;
        n_tests++; if (bus.Gnt !== 3'b001) begin n_fail++; $display("FAIL mid_gnt0: got %b expected 001", bus.Gnt); end
        next_cycle();
        n_tests++; if (bus.Gnt !== 3'b010) begin n_fail++; $display("FAIL mid_gnt1: got %b expected 010", bus.Gnt); end
        next_cycle();
        n_tests++; if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'd4) begin n_fail++; $display("FAIL mid_pre_write: got we=%b a=%0d expected 1/4", bus.RegWrite, bus.WAddr); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.Gnt !== 3'b000 || bus.RegWrite !== 1'b0 || bus.WAddr !== 5'd0 || bus.WData !== 32'd0)
            begin n_fail++; $display("FAIL mid_in_reset: got g=%b we=%b a=%0d d=%0h expected 000/0/0/0", bus.Gnt, bus.RegWrite, bus.WAddr, bus.WData); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (bus.Gnt !== 3'b001) begin n_fail++; $display("FAIL mid_first_gnt: got %b expected 001", bus.Gnt); end
        next_cycle();
        bus.Req = 3'b000;
        n_tests++; if (bus.RegWrite !== 1'b1 || bus.WAddr !== 5'd3 || bus.WData !== 32'h30)
            begin n_fail++; $display("FAIL mid_first_write: got we=%b a=%0d d=%0h expected 1/3/30", bus.RegWrite, bus.WAddr, bus.WData); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        test_reset();
        test_single();
        test_all_request();
        test_zero_reg();
        test_kernel();
        test_late_drop();
        test_saturation();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 Port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port Rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 Port Req, input, 3, meaning per-requester write request, where bit i is requester i (0 ALU writeback, 1 load writeback, 2 multiply writeback).
REQ-006 Ports ReqAddr0/ReqAddr1/ReqAddr2, input, ADDR_W each, meaning per-requester destination register.
REQ-007 Ports ReqData0/ReqData1/ReqData2, input, DATA_W each, meaning per-requester write data.
REQ-008 Port Gnt, output, 3, meaning combinational one-hot grant (or zero).
REQ-009 Port RegWrite, output, 1, meaning registered write enable to the register file.
REQ-010 Port WAddr, output, ADDR_W, meaning registered write address.
REQ-011 Port WData, output, DATA_W, meaning registered write data.
REQ-012 Port Dropped, output, 1, meaning registered one-cycle pulse for a granted write that was discarded.
REQ-013 Port DropCount, output, 8, meaning saturating count of discarded writes.

Function
REQ-014 A transfer SHALL occur on a rising edge where Req[i] and Gnt[i] are both 1.
REQ-015 A requester holds Req, ReqAddr and ReqData stable until its transfer; the block SHALL NOT depend on any other requester behaviour.
REQ-016 Gnt SHALL be zero when Req is zero, and otherwise exactly one-hot.
REQ-017 Arbitration SHALL be round-robin via a 2-bit pointer Ptr (legal values 0..2): the grant goes to the first requesting index found scanning Ptr, Ptr+1, Ptr+2 mod 3.
REQ-018 After a transfer from requester i, Ptr SHALL become (i+1) mod 3; with no transfer, Ptr SHALL hold.
REQ-019 A transfer in cycle N with address A and data D SHALL produce RegWrite=1, WAddr=A, WData=D in cycle N+1 (latency 1), unless discarded.
REQ-020 A transfer to address 0 SHALL be discarded: RegWrite=0 in N+1, Dropped=1 in N+1, DropCount incremented.
REQ-021 In any cycle with no transfer, RegWrite and Dropped SHALL be 0 in the next cycle, and WAddr/WData SHALL hold their last values.
REQ-022 DropCount SHALL saturate at 255 and never wrap.
REQ-023 Continuous requests from all three SHALL be granted in the order 0,1,2,0,... with one transfer per cycle and no idle cycles.
REQ-024 A requester dropping Req before its grant SHALL never be granted or written.

Reset
REQ-025 While Rst_n=0, the block SHALL asynchronously force Ptr=0, RegWrite=0, WAddr=0, WData=0, Dropped=0, DropCount=0, and Gnt=0 regardless of Req.
REQ-026 A transfer whose edge coincides with assertion of Rst_n SHALL be lost, with no write issued after reset.
REQ-027 After reset deassertion, the first grant SHALL follow REQ-017 with Ptr=0.

Configuration
REQ-028 With macro REGWR_PROTECT_KERNEL_EN defined, transfers to addresses 26 and 27 SHALL also be discarded per REQ-020.
REQ-029 Without REGWR_PROTECT_KERNEL_EN, writes to addresses 26 and 27 SHALL be forwarded like any other non-zero address.

Verification
REQ-030 Single request: Req=3'b010, ReqAddr1=5, ReqData1=0x1234 -> Gnt=3'b010 in cycle N; RegWrite=1, WAddr=5, WData=0x1234 in cycle N+1.
REQ-031 All-request: Req=3'b111 held 6 cycles after reset -> Gnt sequence 001,010,100,001,010,100; six writes on consecutive cycles.
REQ-032 Zero-register write: Req=3'b001, ReqAddr0=0 -> RegWrite=0, Dropped=1 in N+1, DropCount=1.
REQ-033 Kernel write: ReqAddr2=26 -> with the macro, Dropped=1 and RegWrite=0; without it, RegWrite=1 and WAddr=26.
REQ-034 Saturation: 300 transfers to address 0 -> DropCount=255.
REQ-035 Mid-run reset: Req=3'b111 with Rst_n pulled low after two grants -> Gnt=0 and RegWrite=0 immediately; after release, first Gnt=3'b001.
